fifo_wr_sched: RTL and testbench
================================

FIFO_WR_SCHED -- requirements
Module: fifo_wr_sched

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  H_ACTIVE, 800, pixels per line;
  V_ACTIVE, 480, lines per frame;
  BURST_LEN, 64, maximum beats per request burst;
  FIFO_HI, 768, maximum FIFO fill level after a burst completes.
REQ-002 fifo_wr_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 sched_en  in  1  level enable; when low, no new frame is accepted.
REQ-005 frame_start  in  1  one-cycle pulse marking the start of an LCD frame.
REQ-006 axis_data_en  in  1  upstream beat valid.
REQ-007 axis_data_requst  out  1  request to upstream; high only in state BURST.
REQ-008 fifo_wr_en  out  1  FIFO write strobe.
REQ-009 fifo_full  in  1  FIFO full flag, active high.
REQ-010 fifo_wr_cnt  in  10  current FIFO fill level in words.
REQ-011 lcd_framesync  out  1  registered copy of frame_start, one-cycle delay.
REQ-012 pix_cnt  out  11  beats accepted in the current line.
REQ-013 line_cnt  out  10  index of the current line.
REQ-014 frame_busy  out  1  high in any state other than IDLE.
REQ-015 frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted.
REQ-016 sync_err  out  1  one-cycle pulse on a frame_start received while busy.
REQ-017 ovf_err  out  1  sticky flag for a beat lost because the FIFO was full.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, WAIT_ROOM, BURST, DONE.
REQ-019 Beat accept SHALL be defined as acc = axis_data_requst & axis_data_en & !fifo_full.
REQ-020 fifo_wr_en SHALL equal acc combinationally, with zero latency.
REQ-021 axis_data_requst SHALL be decoded from the state register only (Moore output).
REQ-022 IDLE -> WAIT_ROOM SHALL occur on frame_start & sched_en, clearing pix_cnt, line_cnt and the burst counter.
REQ-023 The WAIT_ROOM -> BURST condition SHALL be fifo_wr_cnt + rem <= FIFO_HI, where rem = min(BURST_LEN, H_ACTIVE - pix_cnt).
REQ-024 The REQ-023 comparison SHALL be computed at 11-bit width so the sum cannot wrap.
REQ-025 In BURST, each acc SHALL increment pix_cnt and the burst counter (7 bits).
REQ-026 BURST SHALL stay in BURST and hold both counters when axis_data_en is low or fifo_full is high.
REQ-027 Burst end SHALL be the acc on which the burst counter reaches rem-1.
REQ-028 At burst end with the line not complete, next state SHALL be WAIT_ROOM and the burst counter SHALL clear.
REQ-029 At burst end on the last beat of a line (pix_cnt == H_ACTIVE-1), pix_cnt SHALL clear and line_cnt SHALL increment on that same edge.
REQ-030 If the line from REQ-029 is line V_ACTIVE-1, next state SHALL be DONE and frame_done SHALL pulse on the same cycle as the acc.
REQ-031 After the last beat, line_cnt SHALL return to 0, never reaching V_ACTIVE.
REQ-032 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-033 A short tail burst SHALL occur when H_ACTIVE is not a multiple of BURST_LEN; for the defaults, 12 bursts of 64 beats plus 1 burst of 32 beats per line.
REQ-034 frame_start in WAIT_ROOM, BURST or DONE SHALL pulse sync_err and restart the frame:
  state -> WAIT_ROOM; all counters cleared.
  If sched_en is low, state -> IDLE instead.
REQ-035 frame_start SHALL take priority over burst-end and frame-end transitions in the same cycle.
REQ-036 A frame_start coincident with the final acc SHALL still count that beat as written.
REQ-037 A frame_start coincident with the final acc SHALL suppress frame_done.
REQ-038 ovf_err SHALL set when axis_data_requst & axis_data_en & fifo_full.
REQ-039 ovf_err SHALL clear only on rst.
REQ-040 sched_en going low mid-frame SHALL NOT abort the frame; it only blocks the next IDLE exit.
REQ-041 lcd_framesync SHALL be frame_start delayed by one cycle, independent of state.

Reset
REQ-042 While rst is high:
  state SHALL be IDLE;
  pix_cnt, line_cnt and the burst counter SHALL be 0;
  axis_data_requst, fifo_wr_en (via acc), frame_busy, frame_done, sync_err, ovf_err and lcd_framesync SHALL be 0.
REQ-043 Reset asserted mid-burst SHALL drop axis_data_requst on the next edge.
REQ-044 No beat SHALL be accepted in the cycle after reset is sampled.
REQ-045 The first frame_start is honoured one cycle after rst deasserts.

Verification
REQ-046 Full frame, axis_data_en=1, fifo_wr_cnt=0, small params H=100, V=3, BURST_LEN=64 -> exactly 300 fifo_wr_en pulses, bursts 64/36 per line, a single frame_done, line_cnt back to 0.
REQ-047 fifo_wr_cnt=705, defaults -> stays in WAIT_ROOM; drop to 704 -> BURST of 64 beats, then requst low the next cycle.
REQ-048 fifo_full=1 for 5 cycles mid-burst with axis_data_en=1 -> fifo_wr_en=0, counters frozen, ovf_err=1 and sticky, burst resumes and totals remain correct.
REQ-049 frame_start at line 1, pix 40 -> sync_err pulse, line_cnt=0, pix_cnt=0, new frame completes normally.
REQ-050 rst pulsed mid-burst -> next cycle all outputs 0; frame_start after release -> normal frame.
REQ-051 Random axis_data_en gaps (50%) -> beat count per line is exactly H_ACTIVE and requst is never high outside BURST.

Source files
------------

// File: rtl/fifo_wr_sched_if.sv
// Signal bundle between the FIFO write scheduler and its surroundings
// (frame control, upstream stream handshake, FIFO status, status outputs).
interface fifo_wr_sched_if;
   logic        sched_en;
   logic        frame_start;
   logic        axis_data_en;
   logic        axis_data_requst;
   logic        fifo_wr_en;
   logic        fifo_full;
   logic [9:0]  fifo_wr_cnt;
   logic        lcd_framesync;
   logic [10:0] pix_cnt;
   logic [9:0]  line_cnt;
   logic        frame_busy;
   logic        frame_done;
   logic        sync_err;
   logic        ovf_err;

   // master: the scheduler itself
   modport master (
      input  sched_en, frame_start, axis_data_en, fifo_full, fifo_wr_cnt,
      output axis_data_requst, fifo_wr_en, lcd_framesync, pix_cnt, line_cnt,
             frame_busy, frame_done, sync_err, ovf_err
   );

   // slave: the environment feeding and observing the scheduler
   modport slave (
      output sched_en, frame_start, axis_data_en, fifo_full, fifo_wr_cnt,
      input  axis_data_requst, fifo_wr_en, lcd_framesync, pix_cnt, line_cnt,
             frame_busy, frame_done, sync_err, ovf_err
   );
endinterface

// File: rtl/fifo_wr_sched.sv
// Pulls one LCD frame from an upstream stream into a line FIFO in bursts,
// only requesting a burst when the FIFO has room for all of it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no frame in progress, waiting for frame_start & sched_en
// WAIT_ROOM | waiting until the next burst fits under FIFO_HI
// BURST     | requesting beats upstream, writing each accepted beat
// DONE      | one-cycle marker after the last beat of the frame
module fifo_wr_sched #(
   parameter int H_ACTIVE  = 800,
   parameter int V_ACTIVE  = 480,
   parameter int BURST_LEN = 64,
   parameter int FIFO_HI   = 768
) (
   input  logic          fifo_wr_clk,
   input  logic          rst,
   fifo_wr_sched_if.master bus
);

   typedef enum logic [1:0] {IDLE, WAIT_ROOM, BURST, DONE} state_t;

   localparam logic [10:0] H_L    = 11'(H_ACTIVE);
   localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
   localparam logic [10:0] B_L    = 11'(BURST_LEN);
   localparam logic [10:0] HI_L   = 11'(FIFO_HI);

   state_t      state_q, state_d;
   logic [10:0] pix_q, pix_d;
   logic [9:0]  line_q, line_d;
   logic [6:0]  burst_q, burst_d;
   logic        ovf_q, ovf_d;
   logic        sync_q;

   logic        requst;
   logic        acc;
   logic [10:0] pix_base;
   logic [10:0] left;
   logic [10:0] rem;
   logic        room_ok;
   logic        burst_end;
   logic        line_last;
   logic        frame_last;
   logic        restart;

   assign requst = (state_q == BURST);
   assign acc    = requst & bus.axis_data_en & ~bus.fifo_full;

   // rem is sized from the pixel where the current burst began, so it stays
   // constant while pix_cnt advances inside the burst
   assign pix_base   = pix_q - {4'b0, burst_q};
   assign left       = H_L - pix_base;
   assign rem        = (left < B_L) ? left : B_L;
   assign room_ok    = ({1'b0, bus.fifo_wr_cnt} + rem) <= HI_L;
   assign burst_end  = ({4'b0, burst_q} == (rem - 11'd1));
   assign line_last  = (pix_q == H_LAST);
   assign frame_last = line_last & (line_q == V_LAST);
   assign restart    = bus.frame_start & (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      line_d  = line_q;
      burst_d = burst_q;
      ovf_d   = ovf_q | (requst & bus.axis_data_en & bus.fifo_full);
      case (state_q)
         IDLE: begin
            if (bus.frame_start & bus.sched_en) begin
               state_d = WAIT_ROOM;
               pix_d   = '0;
               line_d  = '0;
               burst_d = '0;
            end
         end
         WAIT_ROOM: begin
            if (room_ok) state_d = BURST;
         end
         BURST: begin
            if (acc) begin
               if (burst_end) begin
                  burst_d = '0;
                  if (line_last) begin
                     pix_d = '0;
                     if (frame_last) begin
                        line_d  = '0;
                        state_d = DONE;
                     end else begin
                        line_d  = line_q + 10'd1;
                        state_d = WAIT_ROOM;
                     end
                  end else begin
                     pix_d   = pix_q + 11'd1;
                     state_d = WAIT_ROOM;
                  end
               end else begin
                  pix_d   = pix_q + 11'd1;
                  burst_d = burst_q + 7'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // a new frame_start outranks any burst or frame completion this cycle
      if (restart) begin
         state_d = bus.sched_en ? WAIT_ROOM : IDLE;
         pix_d   = '0;
         line_d  = '0;
         burst_d = '0;
      end
   end

   always_ff @(posedge fifo_wr_clk) begin
      if (rst) begin
         state_q <= IDLE;
         pix_q   <= '0;
         line_q  <= '0;
         burst_q <= '0;
         ovf_q   <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         line_q  <= line_d;
         burst_q <= burst_d;
         ovf_q   <= ovf_d;
         sync_q  <= bus.frame_start;
      end
   end

   assign bus.axis_data_requst = requst;
   assign bus.fifo_wr_en       = acc;
   assign bus.lcd_framesync    = sync_q;
   assign bus.pix_cnt          = pix_q;
   assign bus.line_cnt         = line_q;
   assign bus.frame_busy       = (state_q != IDLE);
   assign bus.frame_done       = ~rst & acc & burst_end & frame_last & ~bus.frame_start;
   assign bus.sync_err         = ~rst & restart;
   assign bus.ovf_err          = ovf_q;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Scoreboard bench for fifo_wr_sched with a 100x3 frame and 64-beat bursts.
module tb_fifo_wr_sched;
   localparam int H = 100;
   localparam int V = 3;

   typedef struct {
      int line;
      int pix;
      int done;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_wr_sched_if bus();

   fifo_wr_sched #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .BURST_LEN(64),
      .FIFO_HI  (768)
   ) dut (
      .fifo_wr_clk(clk),
      .rst        (rst),
      .bus        (bus.master)
   );

   int    checks = 0;
   int    errors = 0;
   beat_t exp_beats[$];
   int    exp_bursts[$];
   int    exp_sync = 0;
   int    run = 0;
   bit    prev_req = 1'b0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_line(input int l, input int n, input bit last_line);
      beat_t b;
      for (int p = 0; p < n; p++) begin
         b.line = l;
         b.pix  = p;
         b.done = (last_line && p == H - 1) ? 1 : 0;
         exp_beats.push_back(b);
      end
   endtask

   task automatic push_frame();
      for (int l = 0; l < V; l++) begin
         push_line(l, H, l == V - 1);
         exp_bursts.push_back(64);
         exp_bursts.push_back(36);
      end
   endtask

   task automatic pulse_start();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      chk("lcd_framesync", int'(bus.lcd_framesync), 1);
   endtask

   task automatic wait_pix(input int l, input int p, input int max);
      int n = 0;
      while (!(int'(bus.line_cnt) == l && int'(bus.pix_cnt) == p) && n < max) begin
         tick();
         n++;
      end
      chk("wait_pix_in_time", int'(n < max), 1);
   endtask

   task automatic wait_done_idle(input string name, input int max, input bit rnd);
      int n = 0;
      bit got = 1'b0;
      while (!got && n < max) begin
         tick();
         if (rnd) begin
            bus.axis_data_en = 1'($urandom_range(0, 1));
            if (n == 50) bus.sched_en = 1'b0;
         end
         #1;
         got = bus.frame_done;
         n++;
      end
      chk({name, "_frame_done_seen"}, int'(got), 1);
      if (got) begin
         tick();
         chk({name, "_done_busy"}, int'(bus.frame_busy), 1);
         chk({name, "_done_req"}, int'(bus.axis_data_requst), 0);
         tick();
         chk({name, "_idle_busy"}, int'(bus.frame_busy), 0);
         chk({name, "_idle_line"}, int'(bus.line_cnt), 0);
      end
      bus.axis_data_en = 1'b1;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_req"},   int'(bus.axis_data_requst), 0);
      chk({name, "_wr_en"}, int'(bus.fifo_wr_en), 0);
      chk({name, "_busy"},  int'(bus.frame_busy), 0);
      chk({name, "_done"},  int'(bus.frame_done), 0);
      chk({name, "_sync"},  int'(bus.sync_err), 0);
      chk({name, "_ovf"},   int'(bus.ovf_err), 0);
      chk({name, "_fsync"}, int'(bus.lcd_framesync), 0);
      chk({name, "_pix"},   int'(bus.pix_cnt), 0);
      chk({name, "_line"},  int'(bus.line_cnt), 0);
   endtask

   initial begin
      int n;
      rst              = 1'b1;
      bus.sched_en     = 1'b1;
      bus.frame_start  = 1'b0;
      bus.axis_data_en = 1'b1;
      bus.fifo_full    = 1'b0;
      bus.fifo_wr_cnt  = 10'd0;

      fork
         forever begin
            beat_t b;
            @(negedge clk);
            if (bus.fifo_wr_en) begin
               if (exp_beats.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL beat_extra line=%0d pix=%0d", bus.line_cnt, bus.pix_cnt);
               end else begin
                  b = exp_beats.pop_front();
                  chk("beat(line*10000+pix*10+done)",
                      int'(bus.line_cnt) * 10000 + int'(bus.pix_cnt) * 10 + int'(bus.frame_done),
                      b.line * 10000 + b.pix * 10 + b.done);
               end
               run++;
            end else if (bus.frame_done) begin
               checks++;
               errors++;
               $display("FAIL done_without_beat frame_done=1 fifo_wr_en=0");
            end
            if (bus.axis_data_requst && !bus.frame_busy) begin
               checks++;
               errors++;
               $display("FAIL req_while_idle requst=1 frame_busy=0");
            end
            if (prev_req && !bus.axis_data_requst) begin
               if (exp_bursts.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL burst_extra len=%0d", run);
               end else begin
                  chk("burst_len", run, exp_bursts.pop_front());
               end
               run = 0;
            end
            prev_req = bus.axis_data_requst;
            if (bus.sync_err) begin
               chk("sync_err_expected", int'(exp_sync > 0), 1);
               if (exp_sync > 0) exp_sync--;
            end
         end
      join_none

      // reset state
      tick();
      tick();
      chk_all_zero("reset");

      // full frame, first frame_start one cycle after reset release
      rst = 1'b0;
      tick();
      push_frame();
      pulse_start();
      chk("t1_busy", int'(bus.frame_busy), 1);
      wait_done_idle("t1", 2000, 1'b0);

      // FIFO room threshold
      bus.fifo_wr_cnt = 10'd705;
      push_frame();
      pulse_start();
      repeat (10) tick();
      chk("t2_hold_req", int'(bus.axis_data_requst), 0);
      chk("t2_hold_busy", int'(bus.frame_busy), 1);
      chk("t2_hold_pix", int'(bus.pix_cnt), 0);
      bus.fifo_wr_cnt = 10'd704;
      wait_done_idle("t2", 2000, 1'b0);
      bus.fifo_wr_cnt = 10'd0;

      // FIFO full stall mid-burst
      push_frame();
      pulse_start();
      wait_pix(0, 20, 200);
      bus.fifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_full_wr_en", int'(bus.fifo_wr_en), 0);
         chk("t3_full_pix", int'(bus.pix_cnt), 20);
         tick();
      end
      bus.fifo_full = 1'b0;
      chk("t3_ovf_set", int'(bus.ovf_err), 1);
      wait_done_idle("t3", 2000, 1'b0);
      chk("t3_ovf_sticky", int'(bus.ovf_err), 1);

      // restart at line 1, pix 40
      push_line(0, H, 1'b0);
      exp_bursts.push_back(64);
      exp_bursts.push_back(36);
      push_line(1, 41, 1'b0);
      exp_bursts.push_back(41);
      push_frame();
      pulse_start();
      wait_pix(1, 40, 500);
      exp_sync++;
      bus.frame_start = 1'b1;
      #1;
      chk("t4_sync_err", int'(bus.sync_err), 1);
      chk("t4_last_beat_written", int'(bus.fifo_wr_en), 1);
      tick();
      bus.frame_start = 1'b0;
      chk("t4_fsync", int'(bus.lcd_framesync), 1);
      chk("t4_line", int'(bus.line_cnt), 0);
      chk("t4_pix", int'(bus.pix_cnt), 0);
      chk("t4_busy", int'(bus.frame_busy), 1);
      wait_done_idle("t4", 2000, 1'b0);

      // reset mid-burst after 10 beats
      bus.axis_data_en = 1'b0;
      push_line(0, 10, 1'b0);
      exp_bursts.push_back(10);
      pulse_start();
      n = 0;
      while (!bus.axis_data_requst && n < 50) begin
         tick();
         n++;
      end
      chk("t5_req_in_time", int'(n < 50), 1);
      bus.axis_data_en = 1'b1;
      repeat (10) tick();
      bus.axis_data_en = 1'b0;
      rst = 1'b1;
      tick();
      chk_all_zero("t5_rst");
      rst = 1'b0;
      tick();
      bus.axis_data_en = 1'b1;
      push_frame();
      pulse_start();
      wait_done_idle("t5", 2000, 1'b0);

      // random upstream gaps, sched_en dropped mid-frame
      push_frame();
      pulse_start();
      wait_done_idle("t6", 6000, 1'b1);

      // frame_start ignored while sched_en is low
      pulse_start();
      chk("t7_not_busy", int'(bus.frame_busy), 0);
      repeat (3) tick();
      chk("t7_no_req", int'(bus.axis_data_requst), 0);
      bus.sched_en = 1'b1;

      tick();
      chk("beats_left", exp_beats.size(), 0);
      chk("bursts_left", exp_bursts.size(), 0);
      chk("sync_left", exp_sync, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
